vga_text_console: RTL and testbench

//  Terminal-style write controller for the 40x25 VGA text RAM (16-bit words {colour[15:8], char[7:0]}).

---
 rtl/vga_text_console.sv | 248 ++++++++++++++++++++++++
 tb/tb_vga_text_console.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_console.sv
// Terminal-style write controller for a COLS x ROWS text RAM: cursor, CR/LF/BS, clear and scroll-up.
// Define VGA_CONSOLE_SCROLL_EN for the scroll sequence; otherwise the cursor wraps to (0,0).
module vga_text_console #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 25,
  parameter logic [15:0] CLEAR_WORD = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_in,
  input  logic [7:0]  col_in,
  input  logic        clear_req,
  output logic        busy,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [9:0]  ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata
);

  localparam logic [9:0] COLS_W    = 10'(COLS);
  localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);
  localparam logic [5:0] LAST_X    = 6'(COLS - 1);
  localparam logic [4:0] LAST_Y    = 5'(ROWS - 1);
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
`ifdef VGA_CONSOLE_SCROLL_EN
  localparam logic [9:0] FILL_BASE = 10'(COLS * (ROWS - 1));
  localparam logic [9:0] LAST_COPY = 10'(COLS * (ROWS - 1) - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUT    = 3'd1,
`ifdef VGA_CONSOLE_SCROLL_EN
    ST_SCR_RD = 3'd2,
    ST_SCR_WR = 3'd3,
`endif
    ST_FILL   = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cx, w_cx_nxt, r_nx, w_nx_nxt;
  logic [4:0]  r_cy, w_cy_nxt, r_ny, w_ny_nxt;
  logic [9:0]  r_addr, w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic        r_we, w_we_nxt;
  logic        r_clear_pending, w_pend_nxt;
  logic [9:0]  w_cur_addr;
  logic        w_accept;
`ifdef VGA_CONSOLE_SCROLL_EN
  logic [9:0]  r_idx, w_idx_nxt;
  logic        r_scroll, w_scroll_nxt;
  logic        r_wsel_rd, w_wsel_nxt;
`else
  logic        w_unused_rdata;
  assign w_unused_rdata = ^ram_rdata;
`endif

  assign w_cur_addr = ({5'd0, r_cy} * COLS_W) + {4'd0, r_cx};
  assign char_ready = (r_state == ST_IDLE) & ~r_clear_pending & ~rst;
  assign w_accept   = char_valid & char_ready;
  assign busy       = (r_state != ST_IDLE) | r_clear_pending;
  assign cursor_x   = r_cx;
  assign cursor_y   = r_cy;
  assign ram_addr   = r_addr;
  assign ram_we     = r_we;
`ifdef VGA_CONSOLE_SCROLL_EN
  // Copy writes forward the RAM read register directly so each moved word costs two clocks.
  assign ram_wdata  = r_wsel_rd ? ram_rdata : r_wdata;
`else
  assign ram_wdata  = r_wdata;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
    w_nx_nxt     = r_nx;
    w_ny_nxt     = r_ny;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = 1'b0;
    w_pend_nxt   = r_clear_pending | clear_req;
`ifdef VGA_CONSOLE_SCROLL_EN
    w_idx_nxt    = r_idx;
    w_scroll_nxt = r_scroll;
    w_wsel_nxt   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_clear_pending) begin
          // A clear_req arriving on the entry cycle queues a second clear.
          w_pend_nxt  = clear_req;
          w_cx_nxt    = 6'd0;
          w_cy_nxt    = 5'd0;
          w_addr_nxt  = 10'd0;
          w_wdata_nxt = CLEAR_WORD;
          w_we_nxt    = 1'b1;
          w_state_nxt = ST_FILL;
        end else if (w_accept) begin
          case (char_in)
            CH_CR: w_cx_nxt = 6'd0;
            CH_LF: begin
              w_cx_nxt = 6'd0;
              if (r_cy != LAST_Y) begin
                w_cy_nxt = r_cy + 5'd1;
              end else begin
`ifdef VGA_CONSOLE_SCROLL_EN
                w_addr_nxt  = COLS_W;
                w_idx_nxt   = 10'd0;
                w_state_nxt = ST_SCR_RD;
`else
                w_cy_nxt    = 5'd0;
`endif
              end
            end
            CH_BS: begin
              if (r_cx != 6'd0) begin
                w_addr_nxt   = w_cur_addr - 10'd1;
                w_wdata_nxt  = CLEAR_WORD;
                w_we_nxt     = 1'b1;
                w_nx_nxt     = r_cx - 6'd1;
                w_ny_nxt     = r_cy;
`ifdef VGA_CONSOLE_SCROLL_EN
                w_scroll_nxt = 1'b0;
`endif
                w_state_nxt  = ST_PUT;
              end else begin
                w_state_nxt  = ST_IDLE;
              end
            end
            default: begin
              w_addr_nxt   = w_cur_addr;
              w_wdata_nxt  = {col_in, char_in};
              w_we_nxt     = 1'b1;
              w_state_nxt  = ST_PUT;
`ifdef VGA_CONSOLE_SCROLL_EN
              w_scroll_nxt = 1'b0;
`endif
              if (r_cx != LAST_X) begin
                w_nx_nxt = r_cx + 6'd1;
                w_ny_nxt = r_cy;
              end else if (r_cy != LAST_Y) begin
                w_nx_nxt = 6'd0;
                w_ny_nxt = r_cy + 5'd1;
              end else begin
                w_nx_nxt = 6'd0;
`ifdef VGA_CONSOLE_SCROLL_EN
                w_ny_nxt     = r_cy;
                w_scroll_nxt = 1'b1;
`else
                w_ny_nxt     = 5'd0;
`endif
              end
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PUT: begin
        w_cx_nxt = r_nx;
        w_cy_nxt = r_ny;
`ifdef VGA_CONSOLE_SCROLL_EN
        if (r_scroll) begin
          w_addr_nxt  = COLS_W;
          w_idx_nxt   = 10'd0;
          w_state_nxt = ST_SCR_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
`ifdef VGA_CONSOLE_SCROLL_EN
      ST_SCR_RD: begin
        w_addr_nxt  = r_idx;
        w_we_nxt    = 1'b1;
        w_wsel_nxt  = 1'b1;
        w_state_nxt = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        if (r_idx == LAST_COPY) begin
          w_addr_nxt  = FILL_BASE;
          w_wdata_nxt = CLEAR_WORD;
          w_we_nxt    = 1'b1;
          w_state_nxt = ST_FILL;
        end else begin
          w_idx_nxt   = r_idx + 10'd1;
          w_addr_nxt  = r_idx + COLS_W + 10'd1;
          w_state_nxt = ST_SCR_RD;
        end
      end
`endif
      ST_FILL: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_addr_nxt = r_addr + 10'd1;
          w_we_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops the write strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cx            <= 6'd0;
      r_cy            <= 5'd0;
      r_nx            <= 6'd0;
      r_ny            <= 5'd0;
      r_addr          <= 10'd0;
      r_wdata         <= 16'h0000;
      r_we            <= 1'b0;
      r_clear_pending <= 1'b0;
`ifdef VGA_CONSOLE_SCROLL_EN
      r_idx           <= 10'd0;
      r_scroll        <= 1'b0;
      r_wsel_rd       <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_cx            <= w_cx_nxt;
      r_cy            <= w_cy_nxt;
      r_nx            <= w_nx_nxt;
      r_ny            <= w_ny_nxt;
      r_addr          <= w_addr_nxt;
      r_wdata         <= w_wdata_nxt;
      r_we            <= w_we_nxt;
      r_clear_pending <= w_pend_nxt;
`ifdef VGA_CONSOLE_SCROLL_EN
      r_idx           <= w_idx_nxt;
      r_scroll        <= w_scroll_nxt;
      r_wsel_rd       <= w_wsel_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboard bench for vga_text_console: a screen/cursor reference model predicts every RAM write.
module tb_vga_text_console;
  localparam int COLS = 40;
  localparam int ROWS = 25;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  char_in = 8'h00;
  logic [7:0]  col_in = 8'h00;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = 16'h0000;

  vga_text_console dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_ready(char_ready),
    .char_in(char_in), .col_in(col_in), .clear_req(clear_req), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [15:0] data; } exp_t;
  exp_t        expq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] salt = 16'h0000;
  logic [15:0] mem [NCELL];
  bit          ram_inited = 1'b0;
  logic [15:0] m_scr [NCELL];
  int          m_cx = 0;
  int          m_cy = 0;

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 40503) ^ salt;
  endfunction

  // Text RAM: registered address, one-clock read latency.
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed write must be the next predicted one.
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected write: addr %0d data %0h none expected", ram_addr, ram_wdata);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("write addr", {22'd0, ram_addr}, e.addr);
        chk("write data", {16'd0, ram_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic m_put(input int a, input logic [15:0] d);
    exp_t e;
    m_scr[a] = d;
    e.addr = a;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic m_newline(output bit scrolled);
    scrolled = 1'b0;
    if (m_cy < ROWS - 1) m_cy++;
    else begin
`ifdef VGA_CONSOLE_SCROLL_EN
      for (int i = 0; i < COLS * (ROWS - 1); i++) m_put(i, m_scr[i + COLS]);
      for (int i = COLS * (ROWS - 1); i < NCELL; i++) m_put(i, 16'h0020);
      scrolled = 1'b1;
`else
      m_cy = 0;
`endif
    end
  endtask

  task automatic m_char(input logic [7:0] c, input logic [7:0] col, output bit rdy_next);
    bit s;
    rdy_next = 1'b1;
    if (c == 8'h0D) m_cx = 0;
    else if (c == 8'h0A) begin
      m_cx = 0;
      m_newline(s);
      rdy_next = !s;
    end else if (c == 8'h08) begin
      if (m_cx > 0) begin
        m_cx--;
        m_put(m_cy * COLS + m_cx, 16'h0020);
        rdy_next = 1'b0;
      end
    end else begin
      m_put(m_cy * COLS + m_cx, {col, c});
      rdy_next = 1'b0;
      m_cx++;
      if (m_cx == COLS) begin
        m_cx = 0;
        m_newline(s);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " cursor_x"}, {26'd0, cursor_x}, m_cx);
    chk({tag, " cursor_y"}, {27'd0, cursor_y}, m_cy);
    chk({tag, " writes pending"}, expq.size(), 32'd0);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] col, input bit wait_done);
    bit rn;
    int n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_in = c;
    col_in = col;
    while (!char_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      chk("ready timeout", {31'd0, char_ready}, 32'd1);
      char_valid = 1'b0;
      return;
    end
    m_char(c, col, rn);
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    chk("ready after char", {31'd0, char_ready}, {31'd0, rn});
    if (wait_done) wait_idle("char");
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_req = 1'b1;
    for (int i = 0; i < NCELL; i++) m_put(i, 16'h0020);
    m_cx = 0;
    m_cy = 0;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic reset_check();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset ram_we", {31'd0, ram_we}, 32'd0);
    chk("reset ready low", {31'd0, char_ready}, 32'd0);
    expq.delete();
    m_cx = 0;
    m_cy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset ready", {31'd0, char_ready}, 32'd1);
    chk("post-reset busy", {31'd0, busy}, 32'd0);
    chk("post-reset cursor_x", {26'd0, cursor_x}, 32'd0);
    chk("post-reset cursor_y", {27'd0, cursor_y}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int r;
    salt = 16'($urandom);
    for (int i = 0; i < NCELL; i++) m_scr[i] = init_word(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ram_we", {31'd0, ram_we}, 32'd0);
    chk("reset ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("reset ram_wdata", {16'd0, ram_wdata}, 32'd0);
    chk("reset cursor_x", {26'd0, cursor_x}, 32'd0);
    chk("reset cursor_y", {27'd0, cursor_y}, 32'd0);
    chk("reset ready", {31'd0, char_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);

    send(8'h41, 8'h1C, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 8'h07, 1'b1);
    send(8'h0A, 8'h00, 1'b1);
    send(8'h0D, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, 1'b1);
    send(8'h08, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 8'h02, 1'b1);
    send(8'h08, 8'h00, 1'b1);

    pulse_clear();
    wait_idle("clear");
    for (int i = 0; i < NCELL; i++) send(8'h30 + 8'(i % 10), 8'h00, 1'b1);

    send(8'h0A, 8'h00, 1'b0);
    repeat (100) @(negedge clk);
    pulse_clear();
    wait_idle("clear after scroll");

    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6) c = 8'h0D;
      else if (r < 16) c = 8'h0A;
      else if (r < 24) c = 8'h08;
      else c = 8'($urandom_range(32, 126));
      send(c, 8'($urandom), 1'b1);
    end

    pulse_clear();
    repeat (300) @(negedge clk);
    reset_check();
    pulse_clear();
    wait_idle("resync clear");

    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00, 1'b1);
    send(8'h0A, 8'h00, 1'b0);
    repeat (201) @(negedge clk);
    reset_check();
    pulse_clear();
    wait_idle("final clear");
    send(8'h5A, 8'h3F, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
